// File: rtl/u_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : divider FSM states, 2-bit encoding
//   cnt_w()     : width of the iteration down-counter for an N-bit divider
package u_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The counter runs from N-1 down to 0, so clog2(N) bits are enough.
  // The counter is never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/u_sub_step.sv
// Combinational W-bit ripple subtractor: diff = x - y, borrow = 1 when x < y.
// Each bit is a full adder fed with x and the inverted y. The chain carry-in
// is 1, so the sum is x + ~y + 1. Borrow is the inverted final carry.
//   x, y   : W-bit unsigned operands
//   diff   : W-bit difference (modulo 2^W)
//   borrow : sign of the true difference
module u_sub_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] y_n;
  logic [W:0]   carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y_n[i]       = ~y[i];
    assign diff[i]      = x[i] ^ y_n[i] ^ carry[i];
    assign carry[i+1]   = (x[i] & y_n[i]) | (carry[i] & (x[i] ^ y_n[i]));
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/u_seq_div8.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// A request is accepted by start while ready is high. N clocks later, done
// pulses for one cycle, and the quotient, remainder and divide-by-zero flag
// are then valid. The results hold until the next result or reset.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request; accepted only while ready=1
//   a, b           : dividend / divisor, sampled on the accepting edge
//   ready          : high in IDLE and DONE
//   done           : one-cycle result strobe
//   u_seq_div8_q/r : quotient / remainder
//   dbz            : last result was a divide by zero
//
// state | meaning
// IDLE  | waiting for start, ready=1
// CALC  | one restoring step per clock, counter N-1 down to 0
// DONE  | done=1 for one cycle, ready=1, start re-launches immediately
module u_seq_div8
  import u_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] u_seq_div8_q,
  output logic [N-1:0] u_seq_div8_r,
  output logic         dbz
);

  localparam int CNT_W = cnt_w(N);

  div_state_e state_q, state_d;

  logic [N-1:0]     quo_q;
  logic [N-1:0]     div_q;
  logic [N:0]       rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;

  logic [N-1:0]     q_res;
  logic [N-1:0]     r_res;
  logic             dbz_res;

  logic             accept;
  logic             last_step;

  logic [N:0]       sub_x;
  logic [N:0]       sub_y;
  logic [N:0]       sub_diff;
  logic             sub_borrow;
  logic [N:0]       rem_step;
  logic [N-1:0]     quo_step;
  logic             rem_top_unused;

  // Shift the next dividend bit into the partial remainder, then try to
  // subtract the divisor.
  assign sub_x = {rem_q[N-1:0], quo_q[N-1]};
  assign sub_y = {1'b0, div_q};

  u_sub_step #(
    .W (N + 1)
  ) u_sub (
    .x      (sub_x),
    .y      (sub_y),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // Restoring step. On a borrow, keep the shifted value.
  assign rem_step = sub_borrow ? sub_x : sub_diff;
  assign quo_step = {quo_q[N-2:0], ~sub_borrow};

  // After a restoring step the remainder is below the divisor, or below
  // 2^N for a zero divisor. Its top bit therefore always reads 0.
  assign rem_top_unused = rem_q[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      q_res   <= '0;
      r_res   <= '0;
      dbz_res <= 1'b0;
    end else begin
      if (accept) begin
        quo_q <= a;
        div_q <= b;
        rem_q <= '0;
        cnt_q <= CNT_W'(N - 1);
        dbz_q <= (b == '0);
      end else if (state_q == CALC) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
      // Results are captured from the final step directly. They stay
      // untouched while a later division is in progress.
      if (last_step) begin
        q_res   <= quo_step;
        r_res   <= rem_step[N-1:0];
        dbz_res <= dbz_q;
      end
    end
  end

  assign u_seq_div8_q = q_res;
  assign u_seq_div8_r = r_res;
  assign dbz          = dbz_res;

endmodule

// File: tb/tb_u_seq_div8.sv
module tb_u_seq_div8;

  localparam int N   = 8;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic         ready;
  logic         done;
  logic [N-1:0] q_out;
  logic [N-1:0] r_out;
  logic         dbz;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  u_seq_div8 #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a_in),
    .b            (b_in),
    .ready        (ready),
    .done         (done),
    .u_seq_div8_q (q_out),
    .u_seq_div8_r (r_out),
    .dbz          (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Shift-and-add reference multiplier, standing in for the Dadda multiplier.
  function automatic logic [2*N-1:0] mul_ref(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) acc = acc + ({{N{1'b0}}, x} << i);
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until done or the cycle budget runs out. The first edge is the
  // accepting edge. With hold=0, start drops after that edge.
  task automatic wait_done(input bit hold, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
      if (!hold) start = 1'b0;
    end while (done !== 1'b1 && lat < 4 * N);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (q_out !== '0 || r_out !== '0 || dbz !== 1'b0)
      begin n_err++; $display("FAIL reset_outputs: got q=%0d r=%0d dbz=%b want 0 0 0", q_out, r_out, dbz); end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0)
      begin n_err++; $display("FAIL reset_release: got ready=%b done=%b want 1 0", ready, done); end
  endtask

  task automatic test_basic();
    logic [N-1:0] ta [4];
    logic [N-1:0] tbv [4];
    exp_t e;
    int lat;
    ta  = '{8'd200, 8'd255, 8'd5, 8'd13};
    tbv = '{8'd7,   8'd1,   8'd9, 8'd0};
    for (int i = 0; i < 4; i++) begin
      a_in  = ta[i];
      b_in  = tbv[i];
      start = 1'b1;
      sb.push_back(model(ta[i], tbv[i]));
      wait_done(1'b0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL basic_latency a=%0d b=%0d: got %0d want %0d", e.a, e.b, lat, LAT); end
      n_cmp++; if (q_out !== e.q) begin n_err++; $display("FAIL basic_q a=%0d b=%0d: got %0d want %0d", e.a, e.b, q_out, e.q); end
      n_cmp++; if (r_out !== e.r) begin n_err++; $display("FAIL basic_r a=%0d b=%0d: got %0d want %0d", e.a, e.b, r_out, e.r); end
      n_cmp++; if (dbz !== e.dbz) begin n_err++; $display("FAIL basic_dbz a=%0d b=%0d: got %b want %b", e.a, e.b, dbz, e.dbz); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_done a=%0d b=%0d: got %b want 1", e.a, e.b, ready); end
      step();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse a=%0d b=%0d: got %b want 0", e.a, e.b, done); end
    end
  endtask

  task automatic test_ignore_and_abort();
    exp_t e;
    logic [N-1:0] held_q;
    logic [N-1:0] held_r;
    int lat;
    int seen;
    held_q = '1;
    held_r = 8'd13;
    a_in  = 8'd100;
    b_in  = 8'd3;
    start = 1'b1;
    sb.push_back(model(8'd100, 8'd3));
    step();
    start = 1'b0;
    step();
    step();
    lat = 3;
    a_in  = 8'd50;
    b_in  = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    lat++;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", ready); end
    n_cmp++; if (q_out !== held_q || r_out !== held_r)
      begin n_err++; $display("FAIL busy_hold: got q=%0d r=%0d want %0d %0d", q_out, r_out, held_q, held_r); end
    while (done !== 1'b1 && lat < 4 * N) begin
      step();
      lat++;
    end
    e = sb.pop_front();
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (q_out !== e.q || r_out !== e.r || dbz !== e.dbz)
      begin n_err++; $display("FAIL ignore_result: got q=%0d r=%0d dbz=%b want %0d %0d %b", q_out, r_out, dbz, e.q, e.r, e.dbz); end
    step();
    a_in  = 8'd100;
    b_in  = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1 || q_out !== '0 || r_out !== '0 || dbz !== 1'b0)
      begin n_err++; $display("FAIL abort_reset: got ready=%b q=%0d r=%0d dbz=%b want 1 0 0 0", ready, q_out, r_out, dbz); end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", ready); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ta [4];
    logic [N-1:0] tbv [4];
    exp_t e;
    int lat;
    ta  = '{8'd99, 8'd0, 8'd255, 8'd1};
    tbv = '{8'd10, 8'd7, 8'd255, 8'd0};
    a_in  = ta[0];
    b_in  = tbv[0];
    start = 1'b1;
    sb.push_back(model(ta[0], tbv[0]));
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b1, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL b2b_latency op%0d: got %0d want %0d", i, lat, LAT); end
      n_cmp++; if (q_out !== e.q || r_out !== e.r || dbz !== e.dbz)
        begin n_err++; $display("FAIL b2b_result op%0d: got q=%0d r=%0d dbz=%b want %0d %0d %b", i, q_out, r_out, dbz, e.q, e.r, e.dbz); end
      if (i < 3) begin
        a_in = ta[i+1];
        b_in = tbv[i+1];
        sb.push_back(model(ta[i+1], tbv[i+1]));
      end else begin
        start = 1'b0;
      end
    end
    step();
    n_cmp++; if (done !== 1'b0 || ready !== 1'b1)
      begin n_err++; $display("FAIL b2b_idle: got done=%b ready=%b want 0 1", done, ready); end
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    int bad_id;
    int bad_lt;
    int bad_lat;
    logic [2*N-1:0] recon;
    bad_id  = 0;
    bad_lt  = 0;
    bad_lat = 0;
    a_in  = N'($urandom_range(0, 255));
    b_in  = N'($urandom_range(1, 255));
    start = 1'b1;
    sb.push_back(model(a_in, b_in));
    for (int i = 0; i < 1500; i++) begin
      wait_done(1'b1, lat);
      e = sb.pop_front();
      recon = mul_ref(q_out, e.b) + {{N{1'b0}}, r_out};
      n_cmp++;
      if (recon !== {{N{1'b0}}, e.a} || q_out !== e.q || dbz !== 1'b0) begin
        n_err++;
        if (bad_id++ < 5) $display("FAIL rand_identity a=%0d b=%0d: got q=%0d r=%0d want q=%0d r=%0d", e.a, e.b, q_out, r_out, e.q, e.r);
      end
      n_cmp++;
      if (!(r_out < e.b)) begin
        n_err++;
        if (bad_lt++ < 5) $display("FAIL rand_rem_lt_b a=%0d b=%0d: got r=%0d want below %0d", e.a, e.b, r_out, e.b);
      end
      n_cmp++;
      if (lat != LAT) begin
        n_err++;
        if (bad_lat++ < 5) $display("FAIL rand_latency op%0d: got %0d want %0d", i, lat, LAT);
      end
      if (i < 1499) begin
        a_in = N'($urandom_range(0, 255));
        b_in = N'($urandom_range(1, 255));
        sb.push_back(model(a_in, b_in));
      end else begin
        start = 1'b0;
      end
    end
    step();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
